imem_program_loader: RTL and testbench
======================================

IMEM_PROGRAM_LOADER -- requirements
Module: imem_program_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning the instruction-memory word-address width.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of encoded-word buffer entries (power of 2).
REQ-003 The block SHALL have port i_Clk, input, 1, the single clock; all state on its rising edge.
REQ-004 The block SHALL have port i_Reset_n, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL have port i_Start, input, 1, a pulse that opens a load session.
REQ-006 The block SHALL have ports i_Req_Valid, input, 1, and o_Req_Ready, output, 1, forming the request handshake.
REQ-007 The block SHALL have port i_Req_Op, input, 5, the instruction select (see REQ-016).
REQ-008 The block SHALL have ports i_Req_Rd, i_Req_Rs1 and i_Req_Rs2, input, 5 each, the register fields; i_Req_Rs2 carries shamt for shift-immediates.
REQ-009 The block SHALL have ports i_Req_Imm, input, 12, the I-type immediate, and i_Req_Last, input, 1, marking the final request of the session.
REQ-010 The block SHALL have ports o_Imem_WrEn, output, 1; o_Imem_Addr, output, ADDR_W; o_Imem_WrData, output, 32; and i_Imem_Ready, input, 1, forming the IMEM write port.
REQ-011 The block SHALL have ports o_Core_Hold, output, 1, and o_Busy, output, 1.
REQ-012 The block SHALL have ports o_Err, output, 1, sticky, and o_Count, output, ADDR_W+1, the words written this session.

Function
REQ-013 States: IDLE, LOAD, DRAIN, DONE; i_Start in IDLE or DONE -> LOAD, clearing address, count, o_Err and FIFO; i_Start in LOAD/DRAIN ignored.
REQ-014 o_Req_Ready = (state==LOAD) && FIFO not full; a transfer occurs when i_Req_Valid && o_Req_Ready; no bypass when full, even if a pop occurs in the same cycle.
REQ-015 An accepted request SHALL be encoded combinationally and pushed into the FIFO on the accepting edge; an accepted request with i_Req_Last=1 -> DRAIN.
REQ-016 The op map SHALL be: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 SLLI, 11 SRLI, 12 SRAI, 13 ADDI, 14 SLTI, 15 SLTIU, 16 XORI, 17 ORI, 18 ANDI.
REQ-017 Ops 0-9 SHALL encode as R-type, opcode 0110011, with funct7 0100000 for SUB/SRA and 0000000 otherwise.
REQ-018 Ops 10-12 SHALL encode as opcode 0010011, with funct7 0100000 for SRAI and 0000000 otherwise, rs2 field = i_Req_Rs2, and i_Req_Imm ignored.
REQ-019 Ops 13-18 SHALL encode as I-type, opcode 0010011, with imm[31:20] = i_Req_Imm.
REQ-020 funct3 SHALL use the standard RV32I values: ADD/SUB/ADDI 000, SLL/SLLI 001, SLT/SLTI 010, SLTU/SLTIU 011, XOR/XORI 100, SRL/SRA/SRLI/SRAI 101, OR/ORI 110, AND/ANDI 111.
REQ-021 An op of 19-31 SHALL be accepted but not pushed, and SHALL set o_Err; i_Req_Last on it still -> DRAIN.
REQ-022 o_Imem_WrEn = FIFO not empty and state in {LOAD, DRAIN}; o_Imem_WrData = FIFO head; data and address SHALL be held stable until i_Imem_Ready.
REQ-023 On o_Imem_WrEn && i_Imem_Ready, the block SHALL pop, increment o_Imem_Addr and increment o_Count.
REQ-024 First-write latency: o_Imem_WrEn SHALL assert the cycle after acceptance into an empty FIFO; throughput SHALL be 1 word/cycle with i_Imem_Ready held high.
REQ-025 A write to address 2^ADDR_W-1 SHALL set o_Err, go to DONE and discard the remaining FIFO entries; the address SHALL never wrap.
REQ-026 DRAIN -> DONE on the cycle the FIFO becomes empty; when Last is accepted with the FIFO empty and no push, LOAD -> DONE directly.
REQ-027 o_Core_Hold = o_Busy = (state in {LOAD, DRAIN}).

Reset
REQ-028 While i_Reset_n=0, the block SHALL immediately set state IDLE, FIFO empty, o_Imem_Addr 0, o_Count 0, o_Err 0, o_Imem_WrEn 0, o_Req_Ready 0, o_Core_Hold 0, o_Busy 0.
REQ-029 Reset mid-session SHALL abort the session; no write SHALL issue after reset assertion; a new i_Start is required.

Verification
REQ-030 Start; ADD rd3,rs1=1,rs2=2, Last=1, Ready=1 -> WrEn next cycle, addr 0, data 0x002081B3; DONE; o_Count=1; hold drops.
REQ-031 SUB 5,6,7 then ADDI 1,0,imm 0xFFF then SRAI 4,4,shamt 3 -> 0x407302B3 @0, 0xFFF00093 @1, 0x40325213 @2.
REQ-032 i_Imem_Ready=0, 5 back-to-back requests -> 4 accepted, o_Req_Ready=0; raise Ready -> 5 writes in order, data stable while stalled.
REQ-033 Op 25 between two ADDs -> 2 writes, addr 0 and 1; o_Err=1 until next i_Start.
REQ-034 ADDR_W=2, 5 requests -> writes to addr 0-3, o_Err=1, DONE, 5th request dropped, o_Count=4.
REQ-035 Assert i_Reset_n=0 during DRAIN with 3 entries queued -> WrEn=0 immediately, all outputs at reset values, no further writes.

Source files
------------

// File: rtl/imem_program_loader.sv
// Instruction-memory program loader.
// Accepts instruction requests (op + register fields + immediate) during a
// load session, encodes them into RV32I ALU words, buffers them in a small
// FIFO and streams them into instruction memory at consecutive addresses
// while holding the core. A session ends once the last request has drained,
// or early when the top memory word has been written.
module imem_program_loader #(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_Clk,
  input  logic              i_Reset_n,
  input  logic              i_Start,
  input  logic              i_Req_Valid,
  output logic              o_Req_Ready,
  input  logic [4:0]        i_Req_Op,
  input  logic [4:0]        i_Req_Rd,
  input  logic [4:0]        i_Req_Rs1,
  input  logic [4:0]        i_Req_Rs2,
  input  logic [11:0]       i_Req_Imm,
  input  logic              i_Req_Last,
  output logic              o_Imem_WrEn,
  output logic [ADDR_W-1:0] o_Imem_Addr,
  output logic [31:0]       o_Imem_WrData,
  input  logic              i_Imem_Ready,
  output logic              o_Core_Hold,
  output logic              o_Busy,
  output logic              o_Err,
  output logic [ADDR_W:0]   o_Count
);

  // FIFO_DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_BASE    = 7'b0000000;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t            state;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    fifo_cnt;
  logic [PTR_W:0]    cnt_next;
  logic              fifo_full;
  logic              fifo_empty;
  logic              active;
  logic              accept;
  logic              op_legal;
  logic              push;
  logic              pop;
  logic              at_top;
  logic [31:0]       enc_word;

  // funct3 for each supported op (0..18); unused codes return 000.
  function automatic logic [2:0] funct3_of(input logic [4:0] op);
    logic [2:0] f3;
    case (op)
      5'd0,  5'd1,  5'd13: f3 = 3'b000;  // ADD SUB ADDI
      5'd2,  5'd10:        f3 = 3'b001;  // SLL SLLI
      5'd3,  5'd14:        f3 = 3'b010;  // SLT SLTI
      5'd4,  5'd15:        f3 = 3'b011;  // SLTU SLTIU
      5'd5,  5'd16:        f3 = 3'b100;  // XOR XORI
      5'd6,  5'd7,
      5'd11, 5'd12:        f3 = 3'b101;  // SRL SRA SRLI SRAI
      5'd8,  5'd17:        f3 = 3'b110;  // OR ORI
      5'd9,  5'd18:        f3 = 3'b111;  // AND ANDI
      default:             f3 = 3'b000;
    endcase
    return f3;
  endfunction

  // Build the 32-bit instruction word for a request.
  // 0..9 register-register, 10..12 shift-immediate (shamt in rs2 slot),
  // 13..18 I-type with the 12-bit immediate in [31:20].
  function automatic logic [31:0] encode(
    input logic [4:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [11:0] imm
  );
    logic [31:0] word;
    logic [2:0]  f3;
    f3 = funct3_of(op);
    if (op <= 5'd9) begin
      word = {((op == 5'd1) || (op == 5'd7)) ? F7_ALT : F7_BASE,
              rs2, rs1, f3, rd, OPC_OP};
    end else if (op <= 5'd12) begin
      word = {(op == 5'd12) ? F7_ALT : F7_BASE,
              rs2, rs1, f3, rd, OPC_OP_IMM};
    end else begin
      word = {imm, rs1, f3, rd, OPC_OP_IMM};
    end
    return word;
  endfunction

  assign active      = (state == LOAD) || (state == DRAIN);
  assign fifo_full   = (fifo_cnt == DEPTH_C);
  assign fifo_empty  = (fifo_cnt == '0);
  assign op_legal    = (i_Req_Op <= 5'd18);
  assign enc_word    = encode(i_Req_Op, i_Req_Rd, i_Req_Rs1, i_Req_Rs2, i_Req_Imm);

  // A full FIFO blocks new requests even if a pop happens this same cycle.
  assign o_Req_Ready = (state == LOAD) && !fifo_full;
  assign accept      = i_Req_Valid && o_Req_Ready;
  assign push        = accept && op_legal;

  assign o_Imem_WrEn   = active && !fifo_empty;
  assign o_Imem_WrData = fifo_mem[rd_ptr];
  assign pop           = o_Imem_WrEn && i_Imem_Ready;
  assign at_top        = (o_Imem_Addr == '1);

  assign cnt_next    = fifo_cnt + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

  assign o_Busy      = active;
  assign o_Core_Hold = active;

  // FIFO storage: encoded words land at the write pointer on every push.
  always_ff @(posedge i_Clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= enc_word;
    end
  end

  // Session FSM with FIFO pointers, write address, word count and error flag.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      o_Imem_Addr <= '0;
      o_Count     <= '0;
      o_Err       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (i_Start) begin
            state       <= LOAD;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            o_Imem_Addr <= '0;
            o_Count     <= '0;
            o_Err       <= 1'b0;
          end
        end
        LOAD, DRAIN: begin
          if (accept && !op_legal) begin
            o_Err <= 1'b1;
          end
          if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
          end
          if (pop) begin
            rd_ptr  <= rd_ptr + PTR_W'(1);
            o_Count <= o_Count + (ADDR_W+1)'(1);
            // The address saturates at the top word instead of wrapping.
            if (!at_top) begin
              o_Imem_Addr <= o_Imem_Addr + ADDR_W'(1);
            end
          end
          fifo_cnt <= cnt_next;

          if (pop && at_top) begin
            // Memory exhausted: flag it, drop whatever is still queued
            // (including a word pushed this same cycle) and end the session.
            o_Err    <= 1'b1;
            state    <= DONE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
          end else if ((state == LOAD) && accept && i_Req_Last) begin
            state <= (cnt_next == '0) ? DONE : DRAIN;
          end else if ((state == DRAIN) && (cnt_next == '0)) begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader: directed scenarios plus
// randomized load sessions compared against a behavioural encoder model.
module tb_imem_program_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a;
  logic        start_b;
  logic        req_valid;
  logic [4:0]  op;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [11:0] imm;
  logic        last;
  logic        imem_ready;

  logic        a_req_ready, a_wren, a_hold, a_busy, a_err;
  logic [9:0]  a_addr;
  logic [31:0] a_wdata;
  logic [10:0] a_count;

  logic        b_req_ready, b_wren, b_hold, b_busy, b_err;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic [2:0]  b_count;

  imem_program_loader #(.ADDR_W(10), .FIFO_DEPTH(4)) dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Start(start_a),
    .i_Req_Valid(req_valid), .o_Req_Ready(a_req_ready),
    .i_Req_Op(op), .i_Req_Rd(rd), .i_Req_Rs1(rs1), .i_Req_Rs2(rs2),
    .i_Req_Imm(imm), .i_Req_Last(last),
    .o_Imem_WrEn(a_wren), .o_Imem_Addr(a_addr), .o_Imem_WrData(a_wdata),
    .i_Imem_Ready(imem_ready), .o_Core_Hold(a_hold), .o_Busy(a_busy),
    .o_Err(a_err), .o_Count(a_count)
  );

  imem_program_loader #(.ADDR_W(2), .FIFO_DEPTH(4)) dut_small (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Start(start_b),
    .i_Req_Valid(req_valid), .o_Req_Ready(b_req_ready),
    .i_Req_Op(op), .i_Req_Rd(rd), .i_Req_Rs1(rs1), .i_Req_Rs2(rs2),
    .i_Req_Imm(imm), .i_Req_Last(last),
    .o_Imem_WrEn(b_wren), .o_Imem_Addr(b_addr), .o_Imem_WrData(b_wdata),
    .i_Imem_Ready(imem_ready), .o_Core_Hold(b_hold), .o_Busy(b_busy),
    .o_Err(b_err), .o_Count(b_count)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit sel   = 1'b0;   // 0: default-size instance, 1: ADDR_W=2 instance
  bit rand_ready = 1'b0;

  // Writes observed on each memory port (sampled mid-cycle).
  logic [31:0] wa_data[$];
  int          wa_addr[$];
  int          wa_cyc[$];
  logic [31:0] wb_data[$];
  int          wb_addr[$];

  // Reference: expected word stream and error flag for the current session.
  logic [31:0] exp_q[$];
  bit          exp_err;

  // RV32I funct3 per op code 0..18.
  localparam logic [2:0] F3 [0:18] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
                                       3'd5, 3'd6, 3'd7, 3'd1, 3'd5, 3'd5, 3'd0,
                                       3'd2, 3'd3, 3'd4, 3'd6, 3'd7};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_wren && imem_ready) begin
      wa_data.push_back(a_wdata);
      wa_addr.push_back(int'(a_addr));
      wa_cyc.push_back(cyc);
    end
    if (b_wren && imem_ready) begin
      wb_data.push_back(b_wdata);
      wb_addr.push_back(int'(b_addr));
    end
  end

  function automatic logic [31:0] model_word(input int o, input int d, input int s1,
                                             input int s2, input int im);
    int unsigned opc, upper, f3;
    opc = (o < 10) ? 32'h33 : 32'h13;
    if (o >= 13) upper = im;
    else upper = s2 + (((o == 1) || (o == 7) || (o == 12)) ? 32'h400 : 32'h0);
    f3 = F3[o];
    return (upper << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | opc;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) imem_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_req(input int o, input int d, input int s1, input int s2,
                           input int im, input bit l);
    req_valid = 1'b1;
    op  = o[4:0];
    rd  = d[4:0];
    rs1 = s1[4:0];
    rs2 = s2[4:0];
    imm = im[11:0];
    last = l;
  endtask

  // Wait for the selected instance to take the driven request; updates the model.
  task automatic wait_accept(input bit must, input int budget);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    while (n < budget) begin
      if ((sel ? b_req_ready : a_req_ready) === 1'b1) begin
        if (int'(op) <= 18) exp_q.push_back(model_word(int'(op), int'(rd), int'(rs1), int'(rs2), int'(imm)));
        else exp_err = 1'b1;
        step();
        ok = 1'b1;
        break;
      end
      step();
      n++;
    end
    req_valid = 1'b0;
    last = 1'b0;
    if (must) chk("accept_timeout", ok, 1);
  endtask

  task automatic send(input int o, input int d, input int s1, input int s2,
                      input int im, input bit l);
    drive_req(o, d, s1, s2, im, l);
    wait_accept(1'b1, 60);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (((sel ? b_busy : a_busy) === 1'b1) && (n < 300)) begin
      step();
      n++;
    end
    chk("idle_timeout", sel ? b_busy : a_busy, 0);
  endtask

  task automatic new_session();
    wa_data.delete(); wa_addr.delete(); wa_cyc.delete();
    wb_data.delete(); wb_addr.delete();
    exp_q.delete();
    exp_err = 1'b0;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic compare_writes_a();
    chk("wr_num", wa_data.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wa_data.size(); i++) begin
      chk($sformatf("wr_data[%0d]", i), wa_data[i], exp_q[i]);
      chk($sformatf("wr_addr[%0d]", i), wa_addr[i], i);
    end
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; req_valid = 1'b0;
    op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0; last = 1'b0;
    imem_ready = 1'b1; exp_err = 1'b0;
    #12;
    chk("rst_busy", a_busy, 0);
    chk("rst_hold", a_hold, 0);
    chk("rst_wren", a_wren, 0);
    chk("rst_ready", a_req_ready, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_count", a_count, 0);
    chk("rst_err", a_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // Single ADD with Last: write one cycle after acceptance.
    new_session();
    chk("t1_busy", a_busy, 1);
    chk("t1_hold", a_hold, 1);
    chk("t1_ready", a_req_ready, 1);
    send(0, 3, 1, 2, 0, 1'b1);
    chk("t1_wren", a_wren, 1);
    chk("t1_addr", a_addr, 0);
    chk("t1_data", a_wdata, 32'h002081B3);
    chk("t1_model", model_word(0, 3, 1, 2, 0), 32'h002081B3);
    step();
    chk("t1_done_busy", a_busy, 0);
    chk("t1_done_hold", a_hold, 0);
    chk("t1_count", a_count, 1);
    chk("t1_err", a_err, 0);
    chk("t1_nwr", wa_data.size(), 1);

    // SUB / ADDI / SRAI back-to-back at full throughput.
    new_session();
    send(1, 5, 6, 7, 0, 1'b0);
    send(13, 1, 0, 0, 12'hFFF, 1'b0);
    send(12, 4, 4, 3, 12'h5A5, 1'b1);
    wait_idle();
    exp_q.delete();
    exp_q.push_back(32'h407302B3);
    exp_q.push_back(32'hFFF00093);
    exp_q.push_back(32'h40325213);
    compare_writes_a();
    if (wa_cyc.size() == 3) begin
      chk("t2_tput1", wa_cyc[1] - wa_cyc[0], 1);
      chk("t2_tput2", wa_cyc[2] - wa_cyc[0], 2);
    end
    chk("t2_count", a_count, 3);

    // Stalled memory: FIFO fills, 5th request waits, head stays stable.
    new_session();
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send($urandom_range(0, 18), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 4095), 1'b0);
    drive_req(9, 7, 8, 9, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("t3_ready_low", a_req_ready, 0);
      chk("t3_wren", a_wren, 1);
      chk("t3_addr_hold", a_addr, 0);
      chk("t3_data_hold", a_wdata, exp_q[0]);
      step();
    end
    imem_ready = 1'b1;
    wait_accept(1'b1, 20);
    wait_idle();
    compare_writes_a();
    chk("t3_count", a_count, 5);

    // Illegal op between two ADDs: skipped, error sticky until Start.
    new_session();
    send(0, 1, 2, 3, 0, 1'b0);
    send(25, 4, 5, 6, 0, 1'b0);
    send(0, 7, 8, 9, 0, 1'b1);
    wait_idle();
    compare_writes_a();
    chk("t4_err", a_err, 1);
    chk("t4_err_model", a_err, exp_err);
    step();
    chk("t4_err_sticky", a_err, 1);
    new_session();
    chk("t4_err_clr", a_err, 0);
    send(30, 0, 0, 0, 0, 1'b1);
    chk("t4_direct_done", a_busy, 0);
    chk("t4_direct_cnt", a_count, 0);
    chk("t4_direct_err", a_err, 1);

    // Randomized sessions with a randomly stalling memory.
    for (int s = 0; s < 5; s++) begin
      int n;
      rand_ready = 1'b1;
      new_session();
      n = $urandom_range(3, 12);
      for (int i = 0; i < n; i++) begin
        int o;
        o = (($urandom % 6) == 0) ? $urandom_range(19, 31) : $urandom_range(0, 18);
        send(o, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 4095), i == n - 1);
      end
      wait_idle();
      rand_ready = 1'b0;
      imem_ready = 1'b1;
      compare_writes_a();
      chk("rnd_err", a_err, exp_err);
      chk("rnd_count", a_count, exp_q.size());
    end

    // Small memory: top address ends the session, 5th word dropped.
    sel = 1'b1;
    new_session();
    for (int i = 0; i < 4; i++) send(i + 2, i + 1, i + 3, i + 5, 0, 1'b0);
    drive_req(5, 9, 9, 9, 0, 1'b1);
    wait_accept(1'b0, 6);
    wait_idle();
    chk("t6_nwr", wb_data.size(), 4);
    for (int i = 0; i < 4 && i < wb_data.size(); i++) begin
      chk($sformatf("t6_data[%0d]", i), wb_data[i], model_word(i + 2, i + 1, i + 3, i + 5, 0));
      chk($sformatf("t6_addr[%0d]", i), wb_addr[i], i);
    end
    chk("t6_count", b_count, 4);
    chk("t6_err", b_err, 1);
    chk("t6_ready", b_req_ready, 0);
    chk("t6_addr_nowrap", b_addr, 3);
    sel = 1'b0;

    // Reset during DRAIN with three words queued.
    new_session();
    imem_ready = 1'b0;
    send(0, 1, 1, 1, 0, 1'b0);
    send(25, 0, 0, 0, 0, 1'b0);
    send(1, 2, 2, 2, 0, 1'b0);
    send(5, 3, 3, 3, 0, 1'b1);
    chk("t7_busy", a_busy, 1);
    chk("t7_wren", a_wren, 1);
    chk("t7_err", a_err, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_wren", a_wren, 0);
    chk("t7_rst_ready", a_req_ready, 0);
    chk("t7_rst_hold", a_hold, 0);
    chk("t7_rst_busy", a_busy, 0);
    chk("t7_rst_addr", a_addr, 0);
    chk("t7_rst_count", a_count, 0);
    chk("t7_rst_err", a_err, 0);
    imem_ready = 1'b1;
    wa_data.delete(); wa_addr.delete(); wa_cyc.delete();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("t7_no_writes", wa_data.size(), 0);
    chk("t7_wren_after", a_wren, 0);
    chk("t7_busy_after", a_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
